fig_08c_plane_writer: RTL
=========================

# fig_08c_plane_writer

Downstream flush stage of the pixel-cache bit matrix. It takes one cached 8-pixel row (64 bits: eight bit-plane bytes) plus its pixel-valid mask and writes the bytes to game-pak RAM in SNES planar tile layout. A plane is written whole when all eight pixels are valid. Otherwise the writer reads the RAM byte and merges it first. It sits between the bit matrix output and the RAM arbiter.

## Interface
- ADDR_W, 17, RAM byte-address width (128 KiB).
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush_req  input  1  start request. Sampled only when busy=0.
- tile_base  input  ADDR_W  byte address of the tile's first byte.
- row  input  3  pixel row within the tile (0-7).
- bpp_mode  input  2  00=2bpp, 01=4bpp, 11=8bpp. 10 is reserved and decodes as 4bpp.
- pix_mask  input  8  bit n=1: pixel n is valid in every plane.
- data  input  64  plane p byte is data[8p+7:8p]. Bit n of each byte is pixel n.
- busy  output  1  high from the accepted request until done.
- done  output  1  one-cycle pulse when the flush completes.
- ram_addr  output  ADDR_W  RAM address for the current access.
- ram_rd_req  output  1  read request, held until ack.
- ram_wr_req  output  1  write request, held until ack.
- ram_wdata  output  8  write data.
- ram_rdata  input  8  read data, valid in the ack cycle.
- ram_ack  input  1  access complete. May arrive in the same cycle the request first asserts.

## Operation
- On flush_req with busy=0, the block captures tile_base, row, bpp_mode, pix_mask and data into internal registers. busy rises the next cycle. Inputs may change afterwards without effect.
- Plane count N: 2, 4 or 8. Planes are processed in order 0 to N-1.
- Address for plane p is tile_base + 16·(p>>1) + 2·row + (p&1), computed modulo 2^ADDR_W (wrap at the top of RAM).
- pix_mask=8'hFF: for each plane, write the captured byte. No reads.
- pix_mask=8'h00: no RAM traffic. done pulses the cycle after capture.
- Any other mask: for each plane, read the RAM byte r, then write (r & ~mask) | (byte & mask).
- States:
  - IDLE goes to RD when the mask is partial, to WR when it is full, and to FIN when it is empty.
  - RD waits for ack, latches the merged byte, then goes to WR.
  - WR waits for ack. After the ack it goes to RD or WR for the next plane, or to FIN after the last plane.
  - FIN pulses done and returns to IDLE.
- Request and done behaviour:
  - ram_rd_req and ram_wr_req are never high together.
  - A request deasserts in the cycle after its ack.
  - ram_addr and ram_wdata are stable while a request is high.
  - flush_req while busy=1 is ignored; the requester must hold or re-issue it.
  - done and a new flush_req in the same cycle: the new request is accepted, because busy is already low in FIN.
- Reset: busy, done, ram_rd_req, ram_wr_req = 0; ram_addr, ram_wdata = 0; state = IDLE.
- Reset mid-operation abandons the flush immediately. A partial tile row in RAM is acceptable. An outstanding request is dropped and no further accesses occur.

## Timing
- Capture cycle C: state leaves IDLE at edge C. busy=1 and the first request are visible in cycle C+1.
- With a same-cycle ack, each access takes 1 cycle:
  - full mask: N cycles of writes, then FIN.
  - partial mask: 2N cycles.
- done is high for exactly one cycle, after the final write ack, and busy is low in that cycle.
- An ack delayed by k cycles adds k cycles to that access only.

## Structure
- Shared package fig_08_pkg holds:
  - the ADDR_W default;
  - the bpp_mode encodings and the plane_count(bpp_mode) function;
  - the state enum.
- One sub-module, fig_08c_tile_addr: a combinational address generator with inputs (tile_base, row, plane) and output ram_addr. It is reused by the fetch stage.
- The merge logic stays inline.

## Test plan
- 2bpp, base=0x00100, row=3, mask=FF, data[15:0]=0xA55A, immediate ack -> writes 0x5A @0x00106, then 0xA5 @0x00107. done in cycle C+3. No reads.
- 8bpp, base=0x00200, row=7, mask=FF -> 8 writes, to 0x20E, 0x20F, 0x21E, 0x21F, 0x22E, 0x22F, 0x23E, 0x23F, in that order.
- 4bpp, mask=0x0F, plane0 data=0xFF, RAM returns 0xA0 -> writes 0xAF. Accesses alternate read and write, 8 in total.
- mask=00 -> no rd_req or wr_req. done one cycle after capture.
- base=0x1FFFE, row=0, 2bpp, full mask -> writes 0x1FFFE, then 0x1FFFF. A second run with row=1 writes 0x00000, then 0x00001 (wrap).
- ram_ack delayed 3 cycles; reset_n asserted during the second write -> all outputs 0 immediately, no further requests. A flush after reset completes normally.

Source files
------------

// File: rtl/fig_08_pkg.sv
// Shared definitions for the pixel-cache flush/fetch path: address width,
// bpp encodings, plane count decode and the plane writer state encoding.
package fig_08_pkg;

  localparam int ADDR_W_DEF = 17;

  typedef enum logic [1:0] {
    BPP_2   = 2'b00,
    BPP_4   = 2'b01,
    BPP_RSV = 2'b10,
    BPP_8   = 2'b11
  } bpp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_FIN
  } st_e;

  // Reserved encoding falls through to 4bpp.
  function automatic logic [3:0] plane_count(input logic [1:0] mode);
    case (mode)
      BPP_2:   plane_count = 4'd2;
      BPP_8:   plane_count = 4'd8;
      default: plane_count = 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/fig_08c_tile_addr.sv
// SNES planar tile byte address: planes pair up into 16-byte blocks, two
// bytes per row, odd plane in the second byte. Wraps at 2^ADDR_W.
module fig_08c_tile_addr
  import fig_08_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] tile_base,
  input  logic [2:0]        row,
  input  logic [2:0]        plane,
  output logic [ADDR_W-1:0] ram_addr
);

  logic [5:0] offs;

  // 16*(plane>>1) + 2*row + (plane&1) packs into disjoint bit fields.
  assign offs     = {plane[2:1], row, plane[0]};
  assign ram_addr = tile_base + ADDR_W'(offs);

endmodule

// File: rtl/fig_08c_plane_writer.sv
// Flushes one cached 8-pixel row (up to eight plane bytes) to RAM, doing a
// read-merge-write per plane when only some pixels are valid.
module fig_08c_plane_writer
  import fig_08_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_req,
  input  logic [ADDR_W-1:0] tile_base,
  input  logic [2:0]        row,
  input  logic [1:0]        bpp_mode,
  input  logic [7:0]        pix_mask,
  input  logic [63:0]       data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_req,
  output logic              ram_wr_req,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              ram_ack
);

  st_e               st;
  logic [ADDR_W-1:0] base_q;
  logic [2:0]        row_q, plane_q, last_q;
  logic [7:0]        mask_q;
  logic [63:0]       data_q;

  logic              accept, mask_full;
  logic [2:0]        nxt_plane, last_nx;
  logic [7:0]        cur_byte, nxt_byte;
  logic [ADDR_W-1:0] ag_base, ag_addr;
  logic [2:0]        ag_row, ag_plane;

  // FIN already has busy low, so a request coinciding with done is taken.
  assign accept    = flush_req && (st == ST_IDLE || st == ST_FIN);
  assign mask_full = (mask_q == 8'hFF);
  assign nxt_plane = plane_q + 3'd1;
  assign last_nx   = 3'(plane_count(bpp_mode) - 4'd1);
  assign cur_byte  = data_q[{plane_q, 3'b000} +: 8];
  assign nxt_byte  = data_q[{nxt_plane, 3'b000} +: 8];

  always_comb begin
    ag_base  = base_q;
    ag_row   = row_q;
    ag_plane = nxt_plane;
    if (accept) begin
      ag_base  = tile_base;
      ag_row   = row;
      ag_plane = 3'd0;
    end
  end

  fig_08c_tile_addr #(.ADDR_W(ADDR_W)) u_addr (
    .tile_base (ag_base),
    .row       (ag_row),
    .plane     (ag_plane),
    .ram_addr  (ag_addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ram_addr   <= '0;
      ram_rd_req <= 1'b0;
      ram_wr_req <= 1'b0;
      ram_wdata  <= '0;
      base_q     <= '0;
      row_q      <= '0;
      plane_q    <= '0;
      last_q     <= '0;
      mask_q     <= '0;
      data_q     <= '0;
    end else begin
      case (st)
        ST_IDLE, ST_FIN: begin
          done <= 1'b0;
          st   <= ST_IDLE;
          if (accept) begin
            base_q   <= tile_base;
            row_q    <= row;
            mask_q   <= pix_mask;
            data_q   <= data;
            plane_q  <= 3'd0;
            last_q   <= last_nx;
            ram_addr <= ag_addr;
            if (pix_mask == 8'h00) begin
              st   <= ST_FIN;
              done <= 1'b1;
              busy <= 1'b0;
            end else if (pix_mask == 8'hFF) begin
              st         <= ST_WR;
              busy       <= 1'b1;
              ram_wr_req <= 1'b1;
              ram_wdata  <= data[7:0];
            end else begin
              st         <= ST_RD;
              busy       <= 1'b1;
              ram_rd_req <= 1'b1;
            end
          end
        end
        ST_RD: if (ram_ack) begin
          ram_rd_req <= 1'b0;
          ram_wr_req <= 1'b1;
          ram_wdata  <= (ram_rdata & ~mask_q) | (cur_byte & mask_q);
          st         <= ST_WR;
        end
        ST_WR: if (ram_ack) begin
          ram_wr_req <= 1'b0;
          if (plane_q == last_q) begin
            st   <= ST_FIN;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            plane_q  <= nxt_plane;
            ram_addr <= ag_addr;
            if (mask_full) begin
              ram_wr_req <= 1'b1;
              ram_wdata  <= nxt_byte;
              st         <= ST_WR;
            end else begin
              ram_rd_req <= 1'b1;
              st         <= ST_RD;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
